// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle controller that sits upstream of a small shift register. It takes an
//   operand, a direction and a shift count, then drives the shifter's load and shift
//   controls. It issues exactly `count` shift cycles, and finally captures the
//   shifted value, the carry (last bit shifted out) and a zero flag.
//
// Ports
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request, sampled only while idle
//   dir      in   1      0 = shift left, 1 = shift right
//   count    in   CNT_W  number of single-bit shifts
//   operand  in   WIDTH  value loaded into the shifter
//   sh_data  out  WIDTH  shifter data input (latched operand)
//   sh_load  out  1      shifter load enable
//   sh_ctrl  out  2      shifter {lsh, rsh}
//   sh_out   in   WIDTH  shifter data output
//   sh_flag  in   1      bit shifted out by the most recent shift
//   busy     out  1      operation in progress
//   done     out  1      one-cycle pulse, result/carry/zero valid from this cycle
//   result   out  WIDTH  captured shifter value
//   carry    out  1      last bit shifted out, 0 when count = 0
//   zero     out  1      result == 0
module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] sh_data,
  output logic             sh_load,
  output logic [1:0]       sh_ctrl,
  input  logic [WIDTH-1:0] sh_out,
  input  logic             sh_flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapture} state_e;

  localparam logic [1:0] CtrlNone  = 2'b00;
  localparam logic [1:0] CtrlLeft  = 2'b10;
  localparam logic [1:0] CtrlRight = 2'b01;

  state_e           state_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q;

  // Outputs are registered and updated together with the state they belong to,
  // so each output always reflects the current state (Moore) without glitches.
  // The async reset forces the shifter controls low immediately on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_data <= '0;
      sh_load <= 1'b0;
      sh_ctrl <= CtrlNone;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sh_data <= operand;
            dir_q   <= dir;
            cnt_q   <= count;
            sh_load <= 1'b1;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          sh_load <= 1'b0;
          rem_q   <= cnt_q;
          if (cnt_q == '0) begin
            state_q <= StCapture;
          end else begin
            sh_ctrl <= dir_q ? CtrlRight : CtrlLeft;
            state_q <= StShift;
          end
        end
        StShift: begin
          rem_q <= rem_q - CNT_W'(1);
          // Last shift edge: drop controls so the shifter holds for capture.
          if (rem_q == CNT_W'(1)) begin
            sh_ctrl <= CtrlNone;
            state_q <= StCapture;
          end
        end
        StCapture: begin
          result  <= sh_out;
          carry   <= (cnt_q != '0) && sh_flag;
          zero    <= (sh_out == '0);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Directed bench: shift_sequencer driving a behavioural 4-bit shift register.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
`timescale 1ns / 1ps
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic [2:0] count;
  logic [3:0] operand;
  logic [3:0] sh_data;
  logic       sh_load;
  logic [1:0] sh_ctrl;
  logic [3:0] sh_out;
  logic       sh_flag;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic       zero;

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer #(
    .WIDTH(4),
    .CNT_W(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .dir    (dir),
    .count  (count),
    .operand(operand),
    .sh_data(sh_data),
    .sh_load(sh_load),
    .sh_ctrl(sh_ctrl),
    .sh_out (sh_out),
    .sh_flag(sh_flag),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  // Behavioural shift register: sh_ctrl = {lsh, rsh}.
  logic [3:0] shreg_q;
  logic       flag_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 4'b0;
      flag_q  <= 1'b0;
    end else if (sh_load) begin
      shreg_q <= sh_data;
      flag_q  <= 1'b0;
    end else if (sh_ctrl == 2'b10) begin
      flag_q  <= shreg_q[3];
      shreg_q <= {shreg_q[2:0], 1'b0};
    end else if (sh_ctrl == 2'b01) begin
      flag_q  <= shreg_q[0];
      shreg_q <= {1'b0, shreg_q[3:1]};
    end
  end
  assign sh_out  = shreg_q;
  assign sh_flag = flag_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and runs until done (bounded). lat counts edges from the
  // edge sampling start to the one raising done; -1 if done never appears.
  task automatic do_op(input logic [3:0] op, input logic d, input logic [2:0] c,
                       output int lat, output int busy_n, output int ctrl_n,
                       output int ctrl_val);
    operand = op;
    dir     = d;
    count   = c;
    start   = 1'b1;
    tick();
    start    = 1'b0;
    lat      = -1;
    busy_n   = 0;
    ctrl_n   = 0;
    ctrl_val = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_n++;
      if (sh_ctrl != 2'b00) begin
        ctrl_n++;
        ctrl_val = int'(sh_ctrl);
      end
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat, busy_n, ctrl_n, ctrl_val, n_done, first_done, second_done;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    dir     = 1'b0;
    count   = 3'd0;
    operand = 4'd0;
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_ctrl", int'(sh_ctrl), 0);
    check("reset_load", int'(sh_load), 0);
    check("reset_data", int'(sh_data), 0);
    check("reset_result", int'(result), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("reset_no_done", int'(done), 0);

    // 1: 0010 >> 1 = 0001, carry 0
    do_op(4'b0010, 1'b1, 3'd1, lat, busy_n, ctrl_n, ctrl_val);
    check("t1_latency", lat, 3);
    check("t1_busy_cycles", busy_n, 3);
    check("t1_ctrl_value", ctrl_val, 1);
    check("t1_result", int'(result), 1);
    check("t1_carry", int'(carry), 0);
    check("t1_zero", int'(zero), 0);
    check("t1_busy_at_done", int'(busy), 0);
    tick();
    check("t1_done_one_cycle", int'(done), 0);
    check("t1_result_held", int'(result), 1);

    // 2: 0010 >> 2 = 0000, carry 1
    do_op(4'b0010, 1'b1, 3'd2, lat, busy_n, ctrl_n, ctrl_val);
    check("t2_latency", lat, 4);
    check("t2_result", int'(result), 0);
    check("t2_carry", int'(carry), 1);
    check("t2_zero", int'(zero), 1);
    tick();

    // 3: 1001 << 1 = 0010, carry 1, left control for one cycle
    do_op(4'b1001, 1'b0, 3'd1, lat, busy_n, ctrl_n, ctrl_val);
    check("t3_result", int'(result), 2);
    check("t3_carry", int'(carry), 1);
    check("t3_zero", int'(zero), 0);
    check("t3_ctrl_cycles", ctrl_n, 1);
    check("t3_ctrl_value", ctrl_val, 2);
    tick();

    // 4: count 0, with a second start raised while busy
    operand = 4'b1010;
    dir     = 1'b1;
    count   = 3'd0;
    start   = 1'b1;
    ctrl_n  = 0;
    tick();
    check("t4_busy", int'(busy), 1);
    if (sh_ctrl != 2'b00) ctrl_n++;
    start = 1'b1;  // ignored: sequencer is busy
    tick();
    start      = 1'b0;
    if (sh_ctrl != 2'b00) ctrl_n++;
    n_done     = 0;
    first_done = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sh_ctrl != 2'b00) ctrl_n++;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = i + 2;
          check("t4_result", int'(result), 10);
          check("t4_carry", int'(carry), 0);
        end
      end
    end
    check("t4_latency", first_done, 2);
    check("t4_done_count", n_done, 1);
    check("t4_ctrl_never", ctrl_n, 0);

    // 5: reset in the second shift cycle of a 5-shift left operation
    operand = 4'b0110;
    dir     = 1'b0;
    count   = 3'd5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5_shifting", int'(sh_ctrl), 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", int'(sh_ctrl), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_data", int'(sh_data), 0);
    check("t5_rst_result", int'(result), 0);
    n_done = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    check("t5_no_done", n_done, 0);
    do_op(4'b0001, 1'b0, 3'd1, lat, busy_n, ctrl_n, ctrl_val);
    check("t5_after_result", int'(result), 2);
    check("t5_after_latency", lat, 3);
    tick();

    // 6: start held high; the second op is accepted in the done cycle.
    // A new op is sampled at the edge after done, so done pulses sit count+3 edges
    // apart with count+2 non-done cycles between them.
    operand = 4'b0011;
    dir     = 1'b1;
    count   = 3'd2;
    start   = 1'b1;
    tick();
    operand     = 4'b0110;  // latched by the second op only
    dir         = 1'b0;
    first_done  = -1;
    second_done = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done && first_done < 0) begin
        first_done = i;
        check("t6_first_result", int'(result), 0);
        check("t6_first_carry", int'(carry), 1);
        check("t6_first_zero", int'(zero), 1);
        tick();
        i++;
        check("t6_no_gap_busy", int'(busy), 1);
      end else if (done && first_done >= 0) begin
        second_done = i;
        start = 1'b0;
        check("t6_second_result", int'(result), 8);
        check("t6_second_carry", int'(carry), 1);
        break;
      end
    end
    start = 1'b0;
    check("t6_first_latency", first_done, 4);
    check("t6_pulse_spacing", second_done - first_done, 5);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
